// File: rtl/rs_syndrome_calc_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers
// for the RS(255,239) syndrome stage.
package rs_syndrome_calc_pkg;

  localparam int N    = 255;
  localparam int K    = 239;
  localparam int T    = 8;
  localparam int M    = 8;
  localparam int NSYN = 2 * T;
  localparam int ROOT0 = 1;

  localparam logic [8:0] PRIM_POLY = 9'h11D;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  function automatic logic [M-1:0] gf_xtime(
    input logic [M-1:0] a
  );
    logic [M-1:0] r;
    r = {a[M-2:0], 1'b0};
    if (a[M-1]) r = r ^ PRIM_POLY[M-1:0];
    return r;
  endfunction

  // alpha^e, evaluated at elaboration for the constant multipliers
  function automatic logic [M-1:0] alpha_pow(
    input int e
  );
    logic [M-1:0] r;
    r = 1;
    for (int i = 0; i < e; i++) r = gf_xtime(r);
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_gf_const_mul.sv
// Multiply by a fixed field element: folds to an XOR
// network because CONST is an elaboration-time constant.
module gf_const_mul
  import rs_syndrome_calc_pkg::*;
#(
  parameter int           m     = M,
  parameter logic [m-1:0] CONST = 1
) (
  input  logic [m-1:0] a_i,
  output logic [m-1:0] p_o
);

  logic [m-1:0] b;

  always_comb begin
    p_o = '0;
    b   = CONST;
    for (int i = 0; i < m; i++) begin
      if (a_i[i]) p_o = p_o ^ b;
      b = {b[m-2:0], 1'b0} ^
          ({m{b[m-1]}} & PRIM_POLY[m-1:0]);
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator: Horner evaluation
// of r(x) at alpha^1..alpha^16 over a serial stream.
module rs_syndrome_calc
  import rs_syndrome_calc_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic [M-1:0]      din,
  output logic              synd_valid,
  output logic [NSYN*M-1:0] synd_out,
  output logic              synd_nz,
  output logic              frame_err
);

  localparam logic [7:0] LAST = 8'(N - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NSYN*M-1:0] acc_q, acc_d;
  logic [NSYN*M-1:0] synd_q, synd_d;
  logic              nz_q, nz_d;
  logic              sv_q, sv_d;
  logic              fe_q, fe_d;
  logic [NSYN*M-1:0] prod;
  logic [NSYN*M-1:0] horner;

  for (genvar j = ROOT0; j < ROOT0 + NSYN; j++) begin : g_mul
    gf_const_mul #(
      .m    (M),
      .CONST(alpha_pow(j))
    ) u_mul (
      .a_i(acc_q[(j-ROOT0+1)*M-1 -: M]),
      .p_o(prod[(j-ROOT0+1)*M-1 -: M])
    );
  end

  assign horner = prod ^ {NSYN{din}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    synd_d  = synd_q;
    nz_d    = nz_q;
    sv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid && din_sop) begin
          acc_d   = {NSYN{din}};
          cnt_d   = 8'd1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (din_valid) begin
          if (din_sop) begin
            // early start: drop partial frame
            fe_d  = 1'b1;
            acc_d = {NSYN{din}};
            cnt_d = 8'd1;
          end else if (cnt_q == LAST) begin
            synd_d  = horner;
            nz_d    = |horner;
            sv_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            acc_d = horner;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      synd_q  <= '0;
      nz_q    <= 1'b0;
      sv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      synd_q  <= synd_d;
      nz_q    <= nz_d;
      sv_q    <= sv_d;
      fe_q    <= fe_d;
    end
  end

  assign synd_valid = sv_q;
  assign synd_out   = synd_q;
  assign synd_nz    = nz_q;
  assign frame_err  = fe_q;

endmodule
